toggle_activity_ctrl: RTL and testbench
=======================================

# toggle_activity_ctrl

Windowed switching-activity controller for the power estimation accelerator. On a start command it samples a vector of monitored nets, such as the q outputs of flip-flop cells under test, for a programmed number of clock cycles. It counts toggles per net with saturating counters, then drains the counts one channel at a time over a valid/ready port to the power-estimation datapath. It sequences the measurement window and shares a single readout port among all channels.

## Interface
Parameters:
- N_SIG, 4, number of monitored nets (≥1)
- CNT_W, 16, toggle counter width per channel
- WIN_W, 16, window-length field width
- IDX_W, $clog2(N_SIG) (minimum 1), channel index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  begin a measurement; honoured only in IDLE
- win_len  in  WIN_W  window length in clock cycles; latched on accepted start
- sig  in  N_SIG  monitored nets; synchronous to clk
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the final readout handshake
- out_valid  out  1  readout word valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_idx  out  IDX_W  channel number of the current word
- out_cnt  out  CNT_W  toggle count of channel out_idx
- out_sat  out  1  the counter of channel out_idx saturated

## Operation
- FSM states: IDLE, ARM, COUNT, DRAIN.
- IDLE: on start=1, latch win_len into win_q, clear all counters and sat flags, clear the window counter, and go to ARM. Otherwise hold.
- ARM, exactly 1 cycle: prev ← sig, which is the baseline sample and is not counted. Next state is COUNT if win_q ≠ 0, else DRAIN.
- COUNT, exactly win_q cycles: each cycle, for every bit i with sig[i] ≠ prev[i], cnt[i] ← cnt[i]+1 unless cnt[i] = 2^CNT_W−1. When the counter is already at 2^CNT_W−1 it holds and sat[i] ← 1. Also prev ← sig and wcnt ← wcnt+1. On the cycle where wcnt = win_q−1, that cycle's comparison is still counted and the next state is DRAIN.
- DRAIN: out_valid=1, out_idx = rd_idx starting at 0, out_cnt = cnt[rd_idx], out_sat = sat[rd_idx]. On handshake, rd_idx increments. A handshake at rd_idx = N_SIG−1 sends the state to IDLE and pulses done.
- Counters and sat flags hold their values after DRAIN until the next accepted start.
- start is ignored in ARM, COUNT and DRAIN. win_len changes after acceptance have no effect.
- sig changes while the FSM is in IDLE or DRAIN are not counted.
- The counter update uses a saturating comparison, not a wrap. No arithmetic exceeds CNT_W bits.

## Timing
- Reset values: state=IDLE, busy=0, done=0, out_valid=0, out_idx=0, out_cnt=0, out_sat=0. All cnt, sat, prev, wcnt, rd_idx and win_q are 0.
- rst=1 in any state, including mid-COUNT or mid-DRAIN, aborts on that edge. No done pulse is issued. rst has priority over start.
- Start accepted at edge E: busy=1 from E+1 (ARM), and COUNT spans edges E+2 … E+1+win_q.
- For win_q = W ≥ 1, out_valid rises at E+2+W. For win_q = 0, out_valid rises at E+2.
- With out_ready held at 1, one word transfers per cycle. done and busy=0 occur on the cycle after the last handshake, i.e. out_valid first high + N_SIG.
- When out_ready=0, out_valid stays high and out_idx, out_cnt and out_sat hold stable.
- out_valid never drops without a handshake, except on rst.
- done and start coincide in IDLE: a new start is accepted on that same cycle.

## Test plan
- N_SIG=4, win_len=10, sig[0] toggles every cycle, sig[1] every 2 cycles, sig[2] constant 1, sig[3] constant 0, out_ready=1 -> counts 10, 5, 0, 0 on idx 0..3. out_sat=0 throughout. done pulses at out_valid first high + 4.
- Same stimulus with out_ready low for 3 cycles at idx 1 -> idx 1 and count 5 held for 4 cycles. Remaining words are unchanged. done is delayed by 3 cycles.
- win_len=0 -> out_valid high 2 cycles after start acceptance. All counts are 0.
- CNT_W=4, win_len=20, sig[0] toggling every cycle -> out_cnt=15 and out_sat=1 for idx 0. Other channels show 0.
- start pulsed during COUNT with a different win_len -> ignored. The window length and counts match the original win_len.
- rst asserted mid-COUNT -> all outputs 0 next cycle with no done. A subsequent start with win_len=4 and sig[0] toggling yields a count of 4.

Source files
------------

// File: rtl/toggle_activity_ctrl.sv
// Windowed toggle counter: samples N_SIG nets for win_len cycles, counts
// transitions per net with saturating counters, then drains them over valid/ready.
module toggle_activity_ctrl #(
    parameter int N_SIG = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int IDX_W = (N_SIG > 1) ? $clog2(N_SIG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_SIG-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SIG - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [WIN_W-1:0]   win_reg;
    logic [WIN_W-1:0]   wcnt_reg;
    logic [N_SIG-1:0]   prev_reg;
    logic [IDX_W-1:0]   rd_idx_reg;
    logic               done_reg;

    logic [N_SIG-1:0]              toggle;
    logic [N_SIG-1:0][CNT_W-1:0]   cnt_all;
    logic [N_SIG-1:0]              sat_all;

    logic accept;
    logic count_en;
    logic last_win;
    logic handshake;
    logic last_word;

    assign accept    = (state_reg == IDLE) && start;
    assign count_en  = (state_reg == COUNT);
    assign last_win  = (wcnt_reg == win_reg - WIN_W'(1));
    assign handshake = (state_reg == DRAIN) && out_ready;
    assign last_word = (rd_idx_reg == LAST_IDX);
    assign toggle    = sig ^ prev_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ARM;
            ARM:     state_next = (win_reg != '0) ? COUNT : DRAIN;
            COUNT:   if (last_win) state_next = DRAIN;
            DRAIN:   if (out_ready && last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            win_reg    <= '0;
            wcnt_reg   <= '0;
            prev_reg   <= '0;
            rd_idx_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= handshake && last_word;
            if (accept) begin
                win_reg    <= win_len;
                wcnt_reg   <= '0;
                rd_idx_reg <= '0;
            end
            // ARM takes the uncounted baseline; COUNT keeps it one cycle behind sig.
            if (state_reg == ARM) begin
                prev_reg <= sig;
            end
            if (count_en) begin
                prev_reg <= sig;
                wcnt_reg <= wcnt_reg + WIN_W'(1);
            end
            if (handshake) begin
                rd_idx_reg <= last_word ? '0 : rd_idx_reg + IDX_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_SIG; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic             sat_reg;

            always_ff @(posedge clk) begin
                if (rst || accept) begin
                    cnt_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (count_en && toggle[gi]) begin
                    // A toggle arriving at full scale is remembered instead of wrapping.
                    if (cnt_reg == CNT_MAX) begin
                        sat_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign cnt_all[gi] = cnt_reg;
            assign sat_all[gi] = sat_reg;
        end
    endgenerate

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign out_valid = (state_reg == DRAIN);
    assign out_idx   = out_valid ? rd_idx_reg : '0;
    assign out_cnt   = out_valid ? cnt_all[rd_idx_reg] : '0;
    assign out_sat   = out_valid ? sat_all[rd_idx_reg] : 1'b0;

endmodule

// File: tb/tb_toggle_activity_ctrl.sv
// Bench for toggle_activity_ctrl: two instances (16-bit and 4-bit counters) share
// stimulus; expected counts come from the recorded sample stream.
module tb_toggle_activity_ctrl;

    localparam int N    = 4;
    localparam int CW_A = 16;
    localparam int CW_B = 4;
    localparam int WW   = 16;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WW-1:0] win_len;
    logic [N-1:0]  sig;
    logic          out_ready;

    logic            busy_a, done_a, valid_a, sat_a;
    logic [IW-1:0]   idx_a;
    logic [CW_A-1:0] cnt_a;
    logic            busy_b, done_b, valid_b, sat_b;
    logic [IW-1:0]   idx_b;
    logic [CW_B-1:0] cnt_b;

    toggle_activity_ctrl #(.N_SIG(N), .CNT_W(CW_A), .WIN_W(WW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig(sig),
        .busy(busy_a), .done(done_a), .out_valid(valid_a), .out_ready(out_ready),
        .out_idx(idx_a), .out_cnt(cnt_a), .out_sat(sat_a)
    );

    toggle_activity_ctrl #(.N_SIG(N), .CNT_W(CW_B), .WIN_W(WW)) dut_b (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig(sig),
        .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_idx(idx_b), .out_cnt(cnt_b), .out_sat(sat_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"},  32'(busy_a | busy_b),   0);
        check_val({tag, "_done"},  32'(done_a | done_b),   0);
        check_val({tag, "_valid"}, 32'(valid_a | valid_b), 0);
        check_val({tag, "_idx"},   32'(idx_a | idx_b),     0);
        check_val({tag, "_cnt_a"}, 32'(cnt_a),             0);
        check_val({tag, "_cnt_b"}, 32'(cnt_b),             0);
        check_val({tag, "_sat"},   32'(sat_a | sat_b),     0);
    endtask

    // 0: random, 1: bit0 every cycle / bit1 every 2 / bit2=1 / bit3=0, 2: bit0 only
    function automatic logic [N-1:0] gen_sig(input int mode, input int k);
        logic [N-1:0] v;
        case (mode)
            1:       v = {1'b0, 1'b1, k[1], k[0]};
            2:       v = {3'b000, k[0]};
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    logic [N-1:0] samples[$];
    int exp_cnt_a[N], exp_cnt_b[N], exp_sat_a[N], exp_sat_b[N];

    task automatic build_expected();
        int raw;
        int max_a = (1 << CW_A) - 1;
        int max_b = (1 << CW_B) - 1;
        for (int i = 0; i < N; i++) begin
            raw = 0;
            for (int k = 1; k < samples.size(); k++) begin
                if (samples[k][i] != samples[k-1][i]) raw++;
            end
            exp_cnt_a[i] = (raw > max_a) ? max_a : raw;
            exp_sat_a[i] = (raw > max_a) ? 1 : 0;
            exp_cnt_b[i] = (raw > max_b) ? max_b : raw;
            exp_sat_b[i] = (raw > max_b) ? 1 : 0;
        end
    endtask

    // Must be called at a negedge; returns at the negedge where done is expected.
    // rmode 0: ready always, 1: ready low 3 cycles at idx 1, 2: random ready.
    task automatic run_window(input int win, input int smode, input int rmode, input bit poke);
        int idx, cyc, low;
        logic [N-1:0] s;
        samples.delete();
        start   = 1'b1;
        win_len = WW'(win);
        sig     = N'($urandom);
        @(negedge clk);
        start   = 1'b0;
        win_len = WW'($urandom);
        check_val("busy_arm", 32'(busy_a & busy_b), 1);
        check_val("done_arm", 32'(done_a | done_b), 0);
        for (int k = 0; k <= win; k++) begin
            if (k > 0) @(negedge clk);
            s = gen_sig(smode, k);
            sig = s;
            samples.push_back(s);
            if (poke && k == 2) begin
                start   = 1'b1;
                win_len = WW'(win + 5);
            end
            if (poke && k == 3) start = 1'b0;
            check_val("valid_early", 32'(valid_a | valid_b), 0);
        end
        @(negedge clk);
        check_val("valid_lat", 32'(valid_a & valid_b), 1);
        build_expected();
        idx = 0;
        cyc = 0;
        low = 0;
        while (idx < N && cyc < 200) begin
            sig = N'($urandom);
            case (rmode)
                1:       begin
                             out_ready = !(idx == 1 && low < 3);
                             if (!out_ready) low++;
                         end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            check_val("valid",  32'(valid_a & valid_b), 1);
            check_val("done_d", 32'(done_a | done_b),   0);
            check_val("idx_a",  32'(idx_a), 32'(idx));
            check_val("idx_b",  32'(idx_b), 32'(idx));
            check_val("cnt_a",  32'(cnt_a), 32'(exp_cnt_a[idx]));
            check_val("sat_a",  32'(sat_a), 32'(exp_sat_a[idx]));
            check_val("cnt_b",  32'(cnt_b), 32'(exp_cnt_b[idx]));
            check_val("sat_b",  32'(sat_b), 32'(exp_sat_b[idx]));
            if (out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_val("drain_words", 32'(idx), N);
        if (rmode == 0) check_val("drain_len", 32'(cyc), N);
        if (rmode == 1) check_val("drain_len", 32'(cyc), N + 3);
        check_val("done",      32'(done_a & done_b),   1);
        check_val("busy_end",  32'(busy_a | busy_b),   0);
        check_val("valid_end", 32'(valid_a | valid_b), 0);
        $display("TXN win=%0d smode=%0d rmode=%0d cnt=%0d,%0d,%0d,%0d cnt4=%0d,%0d,%0d,%0d drain=%0d",
                 win, smode, rmode, exp_cnt_a[0], exp_cnt_a[1], exp_cnt_a[2], exp_cnt_a[3],
                 exp_cnt_b[0], exp_cnt_b[1], exp_cnt_b[2], exp_cnt_b[3], cyc);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        win_len   = '0;
        sig       = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_window(10, 1, 0, 1'b0);
        run_window(10, 1, 1, 1'b0);
        run_window(0,  1, 0, 1'b0);
        run_window(20, 2, 0, 1'b0);
        run_window(12, 1, 0, 1'b1);

        // Abort mid-window: no done, all outputs back to zero.
        @(negedge clk);
        start   = 1'b1;
        win_len = WW'(10);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sig = gen_sig(2, k);
            @(negedge clk);
        end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_idle_outputs("abort");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_val("abort_no_done", 32'(done_a | done_b | busy_a | busy_b), 0);
        end
        run_window(4, 2, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            run_window(int'($urandom_range(0, 40)), 0, 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
